// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time,
// holds the fetched word for the controller and steps the PC on retire.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      Instr,
  output logic [6:0]       op,
  output logic [2:0]       funct3,
  output logic             funct7b5,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PCPlus4,
  input  logic [1:0]       PCSrc,
  input  logic [XLEN-1:0]  ImmExt,
  input  logic [XLEN-1:0]  ALUResult,
  output logic             misalign,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    ERR
  } state_t;

  state_t            state, state_n;
  logic [XLEN-1:0]   pc_q, pc_n;
  logic [XLEN-1:0]   pc_inc;
  logic [XLEN-1:0]   target;
  logic [31:0]       instr_q, instr_n;
  logic              mis_q, mis_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;

  assign pc_inc = pc_q + XLEN'(4);

  // jalr targets drop bit 0; the reserved encoding falls back to PC+4
  always_comb begin
    target = pc_inc;
    unique case (PCSrc)
      2'b00: target = pc_inc;
      2'b01: target = pc_q + ImmExt;
      2'b10: target = ALUResult & ~XLEN'(1);
      2'b11: target = pc_inc;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    instr_n = instr_q;
    mis_n   = mis_q;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (imem_req_ready)
          state_n = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_n = imem_rsp_data;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          cnt_n = cnt_q + CNT_W'(1);
          if (target[1]) begin
            mis_n   = 1'b1;
            state_n = ERR;
          end else begin
            pc_n    = target;
            state_n = REQ;
          end
        end
      end
      ERR: mis_n = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      mis_q   <= mis_n;
      cnt_q   <= cnt_n;
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = (state == HOLD);
  assign Instr          = instr_q;
  assign op             = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign funct7b5       = instr_q[30];
  assign PC             = pc_q;
  assign PCPlus4        = pc_inc;
  assign misalign       = mis_q;
  assign instret        = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory and
// retire traffic, compared each cycle against a transaction-level model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic        misalign;
  logic [31:0] instret;

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .Instr(Instr),
    .op(op),
    .funct3(funct3),
    .funct7b5(funct7b5),
    .PC(PC),
    .PCPlus4(PCPlus4),
    .PCSrc(PCSrc),
    .ImmExt(ImmExt),
    .ALUResult(ALUResult),
    .misalign(misalign),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: what the fetcher is waiting for, plus architectural state
  bit          m_warm;
  bit          m_pend;
  bit          m_fly;
  bit          m_hold;
  bit          m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_cnt;
  int          err_age;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_warm  = 1;
    m_pend  = 0;
    m_fly   = 0;
    m_hold  = 0;
    m_mis   = 0;
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_cnt   = 0;
  endtask

  function automatic logic [31:0] next_pc(input logic [1:0] src,
    input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu);
    case (src)
      2'd1:    return pc + imm;
      2'd2:    return {alu[31:1], 1'b0};
      default: return pc + 32'd4;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] t;
    if (reset) begin
      model_reset();
    end else if (m_warm) begin
      m_warm = 0;
      m_pend = 1;
    end else if (m_pend) begin
      if (imem_req_ready) begin
        m_pend = 0;
        m_fly  = 1;
      end
    end else if (m_fly) begin
      if (imem_rsp_valid) begin
        m_instr = imem_rsp_data;
        m_fly   = 0;
        m_hold  = 1;
      end
    end else if (m_hold && instr_ready) begin
      t = next_pc(PCSrc, m_pc, ImmExt, ALUResult);
      m_cnt  = m_cnt + 1;
      m_hold = 0;
      if (t[1]) m_mis = 1;
      else begin
        m_pc   = t;
        m_pend = 1;
      end
    end
  endtask

  task automatic compare();
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_pend});
    if (m_pend) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_hold});
    chk("Instr", Instr, m_instr);
    chk("op", {25'b0, op}, {25'b0, m_instr[6:0]});
    chk("funct3", {29'b0, funct3}, {29'b0, m_instr[14:12]});
    chk("funct7b5", {31'b0, funct7b5}, {31'b0, m_instr[30]});
    chk("PC", PC, m_pc);
    chk("PCPlus4", PCPlus4, m_pc + 32'd4);
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("instret", instret, m_cnt);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic quiet();
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    instr_ready    = 0;
  endtask

  task automatic do_fetch(input logic [31:0] d);
    quiet();
    imem_req_ready = 1;
    cycle();
    imem_req_ready = 0;
    imem_rsp_valid = 1;
    imem_rsp_data  = d;
    cycle();
    imem_rsp_valid = 0;
  endtask

  task automatic do_retire(input logic [1:0] src, input logic [31:0] imm,
                           input logic [31:0] alu);
    PCSrc       = src;
    ImmExt      = imm;
    ALUResult   = alu;
    instr_ready = 1;
    cycle();
    instr_ready = 0;
  endtask

  task automatic do_reset();
    quiet();
    reset = 1;
    cycle();
    cycle();
    reset = 0;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1;
    quiet();
    imem_rsp_data = 0;
    PCSrc = 0;
    ImmExt = 0;
    ALUResult = 0;
    model_reset();
    err_age = 0;

    // reset then first request
    do_reset();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    cycle();
    chk("first_req", {31'b0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);

    // addi x1,x0,5 then sequential step
    do_fetch(32'h00500093);
    chk("addi_op", {25'b0, op}, 32'h13);
    chk("addi_f3", {29'b0, funct3}, 32'h0);
    chk("addi_f7b5", {31'b0, funct7b5}, 32'h0);
    do_retire(2'd0, 32'h0, 32'h0);
    chk("seq_addr", imem_addr, 32'h4);
    chk("seq_instret", instret, 32'd1);

    // branch back and jalr with bit0 set
    do_fetch(32'h00000013);
    do_retire(2'd0, 32'h0, 32'h0);
    chk("pc8", imem_addr, 32'h8);
    do_fetch(32'hFE000CE3);
    do_retire(2'd1, 32'hFFFFFFF8, 32'h0);
    chk("br_back", imem_addr, 32'h0);
    do_fetch(32'h000080E7);
    do_retire(2'd2, 32'h0, 32'h101);
    chk("jalr", imem_addr, 32'h100);

    // request held while memory stalls
    quiet();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("stall_addr", imem_addr, 32'h100);
    end
    do_fetch(32'h00000013);
    do_retire(2'd3, 32'h0, 32'h0);
    chk("rsvd_src", imem_addr, 32'h104);

    // misaligned branch target faults and stops fetching
    do_reset();
    cycle();
    do_fetch(32'h00000063);
    do_retire(2'd1, 32'h6, 32'h0);
    chk("mis_flag", {31'b0, misalign}, 32'd1);
    chk("mis_pc", PC, 32'h0);
    imem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mis_noreq", {31'b0, imem_req_valid}, 32'd0);
    end

    // reset in WAIT, stale response after release is dropped
    do_reset();
    cycle();
    imem_req_ready = 1;
    cycle();
    quiet();
    reset = 1;
    cycle();
    reset = 0;
    imem_rsp_valid = 1;
    imem_rsp_data = 32'hDEADBEEF;
    cycle();
    imem_rsp_valid = 0;
    chk("stale_instr", Instr, 32'h0);
    chk("fresh_req", {31'b0, imem_req_valid}, 32'd1);
    chk("fresh_addr", imem_addr, 32'h0);
    do_fetch(32'h00A00113);
    chk("fresh_instr", Instr, 32'h00A00113);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      err_age = m_mis ? err_age + 1 : 0;
      reset = ($urandom_range(0, 299) == 0) || (err_age > 6);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if (m_fly)
        imem_rsp_valid = ($urandom_range(0, 2) == 0);
      else if (m_warm || m_pend)
        imem_rsp_valid = ($urandom_range(0, 3) == 0);
      else
        imem_rsp_valid = 0;
      imem_rsp_data = $urandom;
      instr_ready = ($urandom_range(0, 1) == 1);
      PCSrc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        ImmExt = $urandom;
      else
        ImmExt = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
      r = $urandom;
      r[1:0] = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      ALUResult = r;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
